// File: rtl/dlx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dlx_pkg
// Description : Shared definitions for the DLX execute stage. These include
//               the ALU function codes, the branch opcodes, and the encoding
//               of the multiplier sequencer states.
// Revision    : 1.0 - initial release
// ============================================================================
package dlx_pkg;

    // ALU function field
    localparam int FN_W = 5;
    typedef logic [FN_W-1:0] alu_fn_t;

    localparam alu_fn_t FN_ADD = 5'd0;
    localparam alu_fn_t FN_SUB = 5'd1;
    localparam alu_fn_t FN_AND = 5'd2;
    localparam alu_fn_t FN_OR  = 5'd3;
    localparam alu_fn_t FN_XOR = 5'd4;
    localparam alu_fn_t FN_SLL = 5'd5;
    localparam alu_fn_t FN_SRL = 5'd6;
    localparam alu_fn_t FN_SRA = 5'd7;
    localparam alu_fn_t FN_SLT = 5'd8;
    localparam alu_fn_t FN_SEQ = 5'd9;
    localparam alu_fn_t FN_MUL = 5'd10;

    // Conditional branch opcodes
    localparam logic [5:0] OP_BEQZ = 6'h04;
    localparam logic [5:0] OP_BNEZ = 6'h05;

    // Multiplier sequencer state encoding
    typedef logic [1:0] mul_state_t;
    localparam mul_state_t S_IDLE     = 2'd0;
    localparam mul_state_t S_MUL_BUSY = 2'd1;
    localparam mul_state_t S_MUL_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_if
// Description : Bundle for the execute stage. It carries the ID/EX fields into
//               the stage, and carries the EX/MEM fields, the PC redirect and
//               the stall back out.
//               - master : the ID/EX side. It drives the *_in fields and
//                          observes the *_out fields.
//               - slave  : the execute stage itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_stage_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int PC_WIDTH        = 20,
    parameter int OPCODE_WIDTH    = 6,
    parameter int FUNCTION_WIDTH  = 5,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int PC_OFFSET_WIDTH = 26
);
    // ID/EX -> EX
    logic                       valid_in;
    logic                       flush_in;
    logic [DATA_WIDTH-1:0]      data_alu_a_in;
    logic [DATA_WIDTH-1:0]      data_alu_b_in;
    logic [DATA_WIDTH-1:0]      constant_in;
    logic                       imm_inst_in;
    logic [PC_WIDTH-1:0]        new_pc_in;
    logic [OPCODE_WIDTH-1:0]    opcode_in;
    logic [FUNCTION_WIDTH-1:0]  inst_function_in;
    logic [PC_OFFSET_WIDTH-1:0] pc_offset_in;
    logic [REG_ADDR_WIDTH-1:0]  reg_wr_addr_in;
    logic                       reg_wr_en_in;
    logic                       mem_data_rd_en_in;
    logic                       mem_data_wr_en_in;
    logic                       write_back_mux_sel_in;
    logic                       branch_inst_in;
    logic                       jump_inst_in;
    logic                       jump_use_r_in;

    // EX -> upstream / EX/MEM
    logic                       stall_out;
    logic                       pc_load_out;
    logic [PC_WIDTH-1:0]        pc_target_out;
    logic [DATA_WIDTH-1:0]      alu_result_out;
    logic [DATA_WIDTH-1:0]      mem_wr_data_out;
    logic [REG_ADDR_WIDTH-1:0]  reg_wr_addr_out;
    logic                       reg_wr_en_out;
    logic                       mem_data_rd_en_out;
    logic                       mem_data_wr_en_out;
    logic                       write_back_mux_sel_out;

    modport master (
        output valid_in, flush_in, data_alu_a_in, data_alu_b_in, constant_in,
               imm_inst_in, new_pc_in, opcode_in, inst_function_in, pc_offset_in,
               reg_wr_addr_in, reg_wr_en_in, mem_data_rd_en_in, mem_data_wr_en_in,
               write_back_mux_sel_in, branch_inst_in, jump_inst_in, jump_use_r_in,
        input  stall_out, pc_load_out, pc_target_out, alu_result_out, mem_wr_data_out,
               reg_wr_addr_out, reg_wr_en_out, mem_data_rd_en_out, mem_data_wr_en_out,
               write_back_mux_sel_out
    );

    modport slave (
        input  valid_in, flush_in, data_alu_a_in, data_alu_b_in, constant_in,
               imm_inst_in, new_pc_in, opcode_in, inst_function_in, pc_offset_in,
               reg_wr_addr_in, reg_wr_en_in, mem_data_rd_en_in, mem_data_wr_en_in,
               write_back_mux_sel_in, branch_inst_in, jump_inst_in, jump_use_r_in,
        output stall_out, pc_load_out, pc_target_out, alu_result_out, mem_wr_data_out,
               reg_wr_addr_out, reg_wr_en_out, mem_data_rd_en_out, mem_data_wr_en_out,
               write_back_mux_sel_out
    );
endinterface
`default_nettype wire

// File: rtl/ex_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : ex_mul_iter
// Description : Iterative shift-add multiplier. It processes one multiplier
//               bit per cycle over DATA_WIDTH cycles and produces the low
//               DATA_WIDTH bits of the product.
// Ports       : clk, rst_n   - clock, async active-low reset
//               start_i      - accept a_i/b_i (honoured in IDLE only)
//               abort_i      - drop any operation in flight, return to IDLE
//               a_i, b_i     - operands
//               busy_o       - shifting in progress
//               done_o       - product_o valid for this one cycle
//               product_o    - low DATA_WIDTH bits of a*b
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mul_iter
    import dlx_pkg::*;
#(
    parameter int DATA_WIDTH = 32
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] product_o
);
    localparam int CNT_W = $clog2(DATA_WIDTH);

    mul_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_MUL_BUSY;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = a_i;
                    mplier_d = b_i;
                end
            end
            S_MUL_BUSY: begin
                // Bits shifted beyond DATA_WIDTH only affect the discarded high half.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    state_d = S_MUL_DONE;
                end
            end
            S_MUL_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort_i) begin
            state_d = S_IDLE;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign busy_o    = (state_q == S_MUL_BUSY);
    assign done_o    = (state_q == S_MUL_DONE);
    assign product_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : DLX execute stage. It takes the registered ID/EX fields and
//               computes the ALU result. It resolves branches and jumps into a
//               registered PC redirect, and registers the EX/MEM fields.
// Config      : EX_MULT_EN - when defined, MUL uses the iterative multiplier
//               and stalls upstream while the multiplier is busy. When
//               undefined, MUL yields 0 in one cycle and stall_out is tied
//               to 0.
// Ports       : clk, rst_n   - clock, async active-low reset
//               bus (slave)  - ID/EX inputs, stall, PC redirect,
//                              and the EX/MEM outputs (see ex_stage_if)
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
    import dlx_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int PC_WIDTH        = 20,
    parameter int OPCODE_WIDTH    = 6,
    parameter int FUNCTION_WIDTH  = 5,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int PC_OFFSET_WIDTH = 26
)(
    input  logic       clk,
    input  logic       rst_n,
    ex_stage_if.slave  bus
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = PC_WIDTH;

    // ------------------------------------------------------------------
    // Operand select and ALU
    // ------------------------------------------------------------------
    alu_fn_t       w_fn;
    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    logic [4:0]    w_shamt;
    logic [DW-1:0] w_alu;

    assign w_fn    = alu_fn_t'(bus.inst_function_in);
    assign w_a     = bus.data_alu_a_in;
    assign w_b     = bus.imm_inst_in ? bus.constant_in : bus.data_alu_b_in;
    assign w_shamt = w_b[4:0];

    always_comb begin
        w_alu = '0;
        case (w_fn)
            FN_ADD:  w_alu = w_a + w_b;
            FN_SUB:  w_alu = w_a - w_b;
            FN_AND:  w_alu = w_a & w_b;
            FN_OR:   w_alu = w_a | w_b;
            FN_XOR:  w_alu = w_a ^ w_b;
            FN_SLL:  w_alu = w_a << w_shamt;
            FN_SRL:  w_alu = w_a >> w_shamt;
            FN_SRA:  w_alu = $signed(w_a) >>> w_shamt;
            FN_SLT:  w_alu = {{(DW-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            FN_SEQ:  w_alu = {{(DW-1){1'b0}}, (w_a == w_b)};
            // MUL is produced by the multiplier path (or is 0 without it)
            default: w_alu = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Branch / jump resolution
    // ------------------------------------------------------------------
    logic          w_a_zero;
    logic          w_br_taken;
    logic          w_taken;
    logic [PW-1:0] w_br_target;
    logic [PW-1:0] w_j_target;
    logic [PW-1:0] w_target;

    assign w_a_zero    = (w_a == '0);
    assign w_br_taken  = bus.branch_inst_in &&
                         (((bus.opcode_in == OPCODE_WIDTH'(OP_BEQZ)) &&  w_a_zero) ||
                          ((bus.opcode_in == OPCODE_WIDTH'(OP_BNEZ)) && !w_a_zero));
    assign w_taken     = w_br_taken || bus.jump_inst_in;
    assign w_br_target = bus.new_pc_in + bus.constant_in[PW-1:0];
    // The offset is sign-extended (or truncated) to the PC width before the add.
    assign w_j_target  = bus.jump_use_r_in ? w_a[PW-1:0]
                                           : bus.new_pc_in + PW'($signed(bus.pc_offset_in));
    assign w_target    = bus.jump_inst_in ? w_j_target : w_br_target;

    // ------------------------------------------------------------------
    // Multiplier sequencing
    // ------------------------------------------------------------------
    logic w_issue;   // a normal single-cycle instruction retires into EX/MEM

`ifdef EX_MULT_EN
    logic                      w_mul_start;
    logic                      w_mul_busy;
    logic                      w_mul_done;
    logic [DW-1:0]             w_mul_product;
    logic [REG_ADDR_WIDTH-1:0] mul_addr_q;
    logic                      mul_we_q;
    logic                      mul_rd_q;
    logic                      mul_wr_q;
    logic                      mul_wb_q;
    logic [DW-1:0]             mul_st_q;

    assign w_mul_start = !w_mul_busy && !w_mul_done && bus.valid_in &&
                         !bus.flush_in && (w_fn == FN_MUL);
    // The stall is raised in the issue cycle so that the MUL stays parked in
    // ID/EX. It is released in the DONE cycle, so ID/EX advances on the same
    // edge that writes the product.
    assign bus.stall_out = w_mul_start || w_mul_busy;
    assign w_issue       = bus.valid_in && !bus.flush_in && !w_mul_busy &&
                           !w_mul_done && (w_fn != FN_MUL);

    ex_mul_iter #(
        .DATA_WIDTH (DW)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (w_mul_start),
        .abort_i   (bus.flush_in),
        .a_i       (w_a),
        .b_i       (w_b),
        .busy_o    (w_mul_busy),
        .done_o    (w_mul_done),
        .product_o (w_mul_product)
    );

    // The MUL control fields are captured at issue and replayed into EX/MEM
    // together with the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_addr_q <= '0;
            mul_we_q   <= 1'b0;
            mul_rd_q   <= 1'b0;
            mul_wr_q   <= 1'b0;
            mul_wb_q   <= 1'b0;
            mul_st_q   <= '0;
        end else if (w_mul_start) begin
            mul_addr_q <= bus.reg_wr_addr_in;
            mul_we_q   <= bus.reg_wr_en_in;
            mul_rd_q   <= bus.mem_data_rd_en_in;
            mul_wr_q   <= bus.mem_data_wr_en_in;
            mul_wb_q   <= bus.write_back_mux_sel_in;
            mul_st_q   <= bus.data_alu_b_in;
        end
    end
`else
    assign bus.stall_out = 1'b0;
    assign w_issue       = bus.valid_in && !bus.flush_in;
`endif

    // ------------------------------------------------------------------
    // EX/MEM and redirect registers
    // ------------------------------------------------------------------
    logic [DW-1:0]             res_q,  res_d;
    logic [DW-1:0]             st_q,   st_d;
    logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      we_q,   we_d;
    logic                      rd_q,   rd_d;
    logic                      wr_q,   wr_d;
    logic                      wb_q,   wb_d;
    logic                      pcl_q,  pcl_d;
    logic [PW-1:0]             tgt_q,  tgt_d;

    // Anything that does not retire this cycle writes a full bubble.
    always_comb begin
        res_d  = '0;
        st_d   = '0;
        addr_d = '0;
        we_d   = 1'b0;
        rd_d   = 1'b0;
        wr_d   = 1'b0;
        wb_d   = 1'b0;
        pcl_d  = 1'b0;
        tgt_d  = tgt_q;
        if (w_issue) begin
            res_d  = w_alu;
            st_d   = bus.data_alu_b_in;
            addr_d = bus.reg_wr_addr_in;
            we_d   = bus.reg_wr_en_in;
            rd_d   = bus.mem_data_rd_en_in;
            wr_d   = bus.mem_data_wr_en_in;
            wb_d   = bus.write_back_mux_sel_in;
            pcl_d  = w_taken;
            if (w_taken) begin
                tgt_d = w_target;
            end
        end
`ifdef EX_MULT_EN
        else if (!bus.flush_in && w_mul_done) begin
            res_d  = w_mul_product;
            st_d   = mul_st_q;
            addr_d = mul_addr_q;
            we_d   = mul_we_q;
            rd_d   = mul_rd_q;
            wr_d   = mul_wr_q;
            wb_d   = mul_wb_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            st_q   <= '0;
            addr_q <= '0;
            we_q   <= 1'b0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            wb_q   <= 1'b0;
            pcl_q  <= 1'b0;
            tgt_q  <= '0;
        end else begin
            res_q  <= res_d;
            st_q   <= st_d;
            addr_q <= addr_d;
            we_q   <= we_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            wb_q   <= wb_d;
            pcl_q  <= pcl_d;
            tgt_q  <= tgt_d;
        end
    end

    assign bus.alu_result_out         = res_q;
    assign bus.mem_wr_data_out        = st_q;
    assign bus.reg_wr_addr_out        = addr_q;
    assign bus.reg_wr_en_out          = we_q;
    assign bus.mem_data_rd_en_out     = rd_q;
    assign bus.mem_data_wr_en_out     = wr_q;
    assign bus.write_back_mux_sel_out = wb_q;
    assign bus.pc_load_out            = pcl_q;
    assign bus.pc_target_out          = tgt_q;

endmodule
`default_nettype wire
